// File: rtl/cim_input_fifo.sv
// cim_input_fifo: one lane of the 36-bit host-to-CIM input buffer.
// It is a synchronous FIFO with wrap-bit pointers and a registered read port
// that has one cycle of latency. The status flags are decoded from the
// registered pointers.
// Optional build macro: CIM_INPUT_FIFO_ERR_EN adds sticky overflow and
// underflow outputs.
module cim_input_fifo #(
  parameter int DATA_WIDTH = 36,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
`ifdef CIM_INPUT_FIFO_ERR_EN
  output logic                  overflow,
  output logic                  underflow,
`endif
  output logic [ADDR_WIDTH:0]   count
);

  localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;
  localparam logic [ADDR_WIDTH:0] AF_LVL  = AF_LEVEL[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic                  push;
  logic                  pop;

  // Status decode from registered pointers; MSB is the wrap bit
  always_comb begin
    count       = wr_ptr - rd_ptr;
    empty       = (wr_ptr == rd_ptr);
    full        = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                  (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
    almost_full = (count >= AF_LVL);
    pop         = rd_en & ~empty;
    push        = wr_en & (~full | pop);
  end

  // Storage array; contents are never cleared, only made unreachable by reset
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
    end
  end

  // Pointer advance and registered read port (one-cycle read latency)
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= pop;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_ONE;
        rd_data <= mem[rd_ptr[ADDR_WIDTH-1:0]];
      end
    end
  end

`ifdef CIM_INPUT_FIFO_ERR_EN
  // Sticky error flags: dropped write and read-while-empty, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full && !pop) begin
        overflow <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cim_input_fifo.sv
// tb_cim_input_fifo: scenario tasks plus a randomized run, all checked against
// a queue-based reference model of the FIFO.
module tb_cim_input_fifo;

  localparam int DW    = 36;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int AFL   = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic [AW:0]   count;
`ifdef CIM_INPUT_FIFO_ERR_EN
  logic          overflow;
  logic          underflow;
`endif

  cim_input_fifo #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .AF_LEVEL(AFL)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full),
`ifdef CIM_INPUT_FIFO_ERR_EN
    .overflow(overflow), .underflow(underflow),
`endif
    .count(count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Reference model: occupancy is the queue, read port is the last popped word
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rd_data = '0;
  logic          m_rd_valid = 1'b0;
  logic          m_ovf = 1'b0;
  logic          m_udf = 1'b0;

  function automatic int m_count();
    return q.size();
  endfunction

  // Drive one cycle of traffic and advance the model by the same rules
  task automatic step(input logic we, input logic [DW-1:0] wd, input logic re);
    bit was_full, was_empty, do_pop, do_push;
    wr_en = we; wr_data = wd; rd_en = re;
    @(posedge clk);
    #1;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    do_pop    = re && !was_empty;
    do_push   = we && (!was_full || do_pop);
    m_rd_valid = do_pop;
    if (do_pop)  m_rd_data = q.pop_front();
    if (do_push) q.push_back(wd);
    if (we && was_full && !do_pop) m_ovf = 1'b1;
    if (re && was_empty) m_udf = 1'b1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic step_rst(input logic we, input logic [DW-1:0] wd);
    rst = 1'b1; wr_en = we; wr_data = wd; rd_en = 1'b0;
    @(posedge clk);
    #1;
    q.delete();
    m_rd_data = '0; m_rd_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    rst = 1'b0; wr_en = 1'b0;
  endtask

  task automatic test_reset();
    step_rst(1'b0, '0);
    step_rst(1'b0, '0);
    vectors++;
    if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags count=%0d empty=%b full=%b af=%b required 0/1/0/0",
               count, empty, full, almost_full);
    end
    vectors++;
    if (rd_valid !== 1'b0 || rd_data !== '0) begin
      errors++;
      $display("FAIL reset_read rd_valid=%b rd_data=%h required 0/0", rd_valid, rd_data);
    end
`ifdef CIM_INPUT_FIFO_ERR_EN
    vectors++;
    if (overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_err ovf=%b udf=%b required 0/0", overflow, underflow);
    end
`endif
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, DW'(i + 1), 1'b0);
      vectors++;
      if (count !== 5'(i + 1) || full !== (i + 1 == DEPTH) ||
          almost_full !== (i + 1 >= AFL) || empty !== 1'b0) begin
        errors++;
        $display("FAIL fill[%0d] count=%0d full=%b af=%b empty=%b required %0d/%b/%b/0",
                 i, count, full, almost_full, empty, i + 1, i + 1 == DEPTH, i + 1 >= AFL);
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, '0, 1'b1);
      vectors++;
      if (rd_valid !== 1'b1 || rd_data !== DW'(i + 1)) begin
        errors++;
        $display("FAIL drain[%0d] rd_valid=%b rd_data=%h required 1/%h",
                 i, rd_valid, rd_data, DW'(i + 1));
      end
    end
    vectors++;
    if (empty !== 1'b1 || count !== 5'd0) begin
      errors++;
      $display("FAIL drain_end empty=%b count=%0d required 1/0", empty, count);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) step(1'b1, {4'h3, 32'($urandom)}, 1'b0);
    step(1'b1, 36'hF_FFFF_FFFF, 1'b0);
    vectors++;
    if (count !== 5'd16 || full !== 1'b1) begin
      errors++;
      $display("FAIL ovf_count count=%0d full=%b required 16/1", count, full);
    end
`ifdef CIM_INPUT_FIFO_ERR_EN
    vectors++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_flag overflow=%b required 1", overflow);
    end
`endif
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, '0, 1'b1);
      vectors++;
      if (rd_valid !== 1'b1 || rd_data !== m_rd_data || rd_data === 36'hF_FFFF_FFFF) begin
        errors++;
        $display("FAIL ovf_read[%0d] rd_valid=%b rd_data=%h required 1/%h",
                 i, rd_valid, rd_data, m_rd_data);
      end
    end
  endtask

  task automatic test_empty_simul();
    step(1'b1, 36'h0_DEAD_BEEF, 1'b1);
    vectors++;
    if (rd_valid !== 1'b0 || count !== 5'd1) begin
      errors++;
      $display("FAIL empty_simul rd_valid=%b count=%0d required 0/1", rd_valid, count);
    end
    step(1'b0, '0, 1'b1);
    vectors++;
    if (rd_valid !== 1'b1 || rd_data !== 36'h0_DEAD_BEEF) begin
      errors++;
      $display("FAIL empty_simul_read rd_valid=%b rd_data=%h required 1/0deadbeef",
               rd_valid, rd_data);
    end
  endtask

  task automatic test_full_simul();
    for (int i = 0; i < DEPTH; i++) step(1'b1, {4'h5, 32'($urandom)}, 1'b0);
    step(1'b1, 36'hA_AAAA_AAAA, 1'b1);
    vectors++;
    if (rd_valid !== 1'b1 || rd_data !== m_rd_data || full !== 1'b1 || count !== 5'd16) begin
      errors++;
      $display("FAIL full_simul rd_valid=%b rd_data=%h full=%b count=%0d required 1/%h/1/16",
               rd_valid, rd_data, full, count, m_rd_data);
    end
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, '0, 1'b1);
      vectors++;
      if (rd_data !== m_rd_data || (i == DEPTH - 1 && rd_data !== 36'hA_AAAA_AAAA)) begin
        errors++;
        $display("FAIL full_simul_read[%0d] rd_data=%h required %h", i, rd_data, m_rd_data);
      end
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 40; i++) begin
      step(1'b1, DW'(i), 1'b0);
      vectors++;
      if (count !== 5'd1) begin
        errors++;
        $display("FAIL wrap_count[%0d] count=%0d required 1", i, count);
      end
      step(1'b0, '0, 1'b1);
      vectors++;
      if (rd_valid !== 1'b1 || rd_data !== DW'(i) || count !== 5'd0) begin
        errors++;
        $display("FAIL wrap_read[%0d] rd_valid=%b rd_data=%h count=%0d required 1/%h/0",
                 i, rd_valid, rd_data, count, DW'(i));
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) step(1'b1, {4'h9, 32'($urandom)}, 1'b0);
    step(1'b0, '0, 1'b1);
    step_rst(1'b1, 36'h1_2345_6789);
    vectors++;
    if (count !== 5'd0 || empty !== 1'b1 || rd_valid !== 1'b0 || rd_data !== '0) begin
      errors++;
      $display("FAIL reset_mid count=%0d empty=%b rd_valid=%b rd_data=%h required 0/1/0/0",
               count, empty, rd_valid, rd_data);
    end
    step(1'b0, '0, 1'b1);
    vectors++;
    if (rd_valid !== 1'b0 || rd_data !== '0 || count !== 5'd0) begin
      errors++;
      $display("FAIL reset_mid_read rd_valid=%b rd_data=%h count=%0d required 0/0/0",
               rd_valid, rd_data, count);
    end
`ifdef CIM_INPUT_FIFO_ERR_EN
    vectors++;
    if (underflow !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_err udf=%b ovf=%b required 1/0", underflow, overflow);
    end
`endif
  endtask

  task automatic test_random();
    logic [3:0] hi;
    for (int i = 0; i < 400; i++) begin
      hi = 4'($urandom);
      step(1'($urandom_range(0, 99) < 55), {hi, 32'($urandom)}, 1'($urandom_range(0, 99) < 45));
      vectors++;
      if (count !== 5'(m_count()) || full !== (m_count() == DEPTH) ||
          empty !== (m_count() == 0) || almost_full !== (m_count() >= AFL)) begin
        errors++;
        $display("FAIL rand_status[%0d] count=%0d full=%b empty=%b af=%b required count %0d",
                 i, count, full, empty, almost_full, m_count());
      end
      vectors++;
      if (rd_valid !== m_rd_valid || rd_data !== m_rd_data) begin
        errors++;
        $display("FAIL rand_read[%0d] rd_valid=%b rd_data=%h required %b/%h",
                 i, rd_valid, rd_data, m_rd_valid, m_rd_data);
      end
`ifdef CIM_INPUT_FIFO_ERR_EN
      vectors++;
      if (overflow !== m_ovf || underflow !== m_udf) begin
        errors++;
        $display("FAIL rand_err[%0d] ovf=%b udf=%b required %b/%b",
                 i, overflow, underflow, m_ovf, m_udf);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_empty_simul();
    test_reset();
    test_full_simul();
    test_wrap();
    test_reset_mid();
    test_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
